// File: rtl/inst_buffer_dual_pkg.sv
// Purpose: shared types and constants for the dual-issue instruction buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package inst_buffer_dual_pkg;

    // Decode issue decision encoding.
    localparam logic ISSUE_DUAL   = 1'b1;
    localparam logic ISSUE_SINGLE = 1'b0;

    // Width of the branch-predictor correction pack. Its top bit is the valid/taken flag.
    localparam int SIZE_OF_CORR_PACK = 88;

    // Zero word and the instruction word presented when a slot is empty (sll $0,$0,0).
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // One buffered fetch slot.
    typedef struct packed {
        logic [31:0]                  inst;
        logic [31:0]                  addr;
        logic [SIZE_OF_CORR_PACK-1:0] corr;
    } instbuf_entry_t;

    // Number of entries retired this cycle. A dual decision with only one valid
    // entry degrades to a single retire, and nothing retires without a handshake.
    function automatic logic [1:0] calc_pop_n(
        input logic issued,
        input logic issue,
        input logic has1,
        input logic has2
    );
        logic [1:0] n;
        n = 2'd0;
        if (issued && has1) begin
            n = (issue == ISSUE_DUAL && has2) ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/instbuf_ram.sv
// Purpose: DEPTH-entry register array, two write ports and two asynchronous read ports.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none; the caller guarantees the two write addresses differ.
module instbuf_ram
    import inst_buffer_dual_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter int  ADDR_W  = 4,
    parameter type entry_t = instbuf_entry_t
) (
    input  logic              clk,
    input  logic              wr0_en_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  entry_t            wr0_data_i,
    input  logic              wr1_en_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  entry_t            wr1_data_i,
    input  logic [ADDR_W-1:0] rd0_addr_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output entry_t            rd0_data_o,
    output entry_t            rd1_data_o
);

    // Storage is intentionally not reset; occupancy masking in the parent hides stale data.
    entry_t mem_q [DEPTH];

    // Write both fetch slots on the rising edge.
    always_ff @(posedge clk) begin
        if (wr0_en_i) begin
            mem_q[wr0_addr_i] <= wr0_data_i;
        end
        if (wr1_en_i) begin
            mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    assign rd0_data_o = mem_q[rd0_addr_i];
    assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/inst_buffer_dual.sv
// Purpose: circular instruction queue between fetch and dual-issue decode (optional perf counters: INSTBUF_PERF_EN).
// Latency: pushed entries appear at the head outputs one cycle later; no same-cycle bypass.
// Backpressure: full_o when fewer than 2 slots are free; a push offered while full_o is high is dropped.
module inst_buffer_dual
    import inst_buffer_dual_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CORR_W = SIZE_OF_CORR_PACK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              if_inst1_valid,
    input  logic              if_inst2_valid,
    input  logic [31:0]       if_inst1,
    input  logic [31:0]       if_inst2,
    input  logic [31:0]       if_addr1,
    input  logic [31:0]       if_addr2,
    input  logic [CORR_W-1:0] if_corr1,
    input  logic [CORR_W-1:0] if_corr2,
    output logic              full_o,

    input  logic              issue_i,
    input  logic              issued_i,
    output logic              issue_en_o,
    output logic              inst2_valid_o,
    output logic [31:0]       inst1_o,
    output logic [31:0]       inst2_o,
    output logic [31:0]       inst1_addr_o,
    output logic [31:0]       inst2_addr_o,
    output logic [CORR_W-1:0] inst1_corr_o,
    output logic [CORR_W-1:0] inst2_corr_o,
    output logic [ADDR_W:0]   count_o
`ifdef INSTBUF_PERF_EN
    ,
    output logic [31:0]       perf_dual_o,
    output logic [31:0]       perf_single_o,
    output logic [31:0]       perf_full_o
`endif
);

    localparam int CNT_W = ADDR_W + 1;

    // Entry layout follows the package struct but tracks this instance's CORR_W.
    typedef struct packed {
        logic [31:0]       inst;
        logic [31:0]       addr;
        logic [CORR_W-1:0] corr;
    } entry_t;

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [1:0] push_n;
    logic [1:0] pop_n;
    logic       has1;
    logic       has2;

    entry_t wr0_data, wr1_data;
    entry_t rd0_data, rd1_data;

    // Occupancy flags, all from registered count.
    assign has1   = (count_q != '0);
    assign has2   = (count_q >= CNT_W'(2));
    assign full_o = (count_q > CNT_W'(DEPTH - 2));

    assign pop_n  = calc_pop_n(issued_i, issue_i, has1, has2);

    // Accept 0, 1 or 2 fetch slots; slot 2 only counts alongside slot 1.
    always_comb begin
        push_n = 2'd0;
        if (!full_o && !flush && if_inst1_valid) begin
            push_n = if_inst2_valid ? 2'd2 : 2'd1;
        end
    end

    // Pointer and occupancy next state; flush discards the same-cycle push and pop.
    always_comb begin
        head_d  = head_q + ADDR_W'(pop_n);
        tail_d  = tail_q + ADDR_W'(push_n);
        count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign wr0_data = '{inst: if_inst1, addr: if_addr1, corr: if_corr1};
    assign wr1_data = '{inst: if_inst2, addr: if_addr2, corr: if_corr2};

    instbuf_ram #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .entry_t (entry_t)
    ) u_ram (
        .clk        (clk),
        .wr0_en_i   (push_n != 2'd0),
        .wr0_addr_i (tail_q),
        .wr0_data_i (wr0_data),
        .wr1_en_i   (push_n == 2'd2),
        .wr1_addr_i (tail_q + ADDR_W'(1)),
        .wr1_data_i (wr1_data),
        .rd0_addr_i (head_q),
        .rd1_addr_i (head_q + ADDR_W'(1)),
        .rd0_data_o (rd0_data),
        .rd1_data_o (rd1_data)
    );

    // Head outputs, zeroed when the slot holds no valid entry so stale storage never leaks.
    always_comb begin
        issue_en_o    = has1;
        inst2_valid_o = has2;
        inst1_o       = ZeroWord;
        inst1_addr_o  = ZeroWord;
        inst1_corr_o  = '0;
        inst2_o       = NOP_INST;
        inst2_addr_o  = ZeroWord;
        inst2_corr_o  = '0;
        if (has1) begin
            inst1_o      = rd0_data.inst;
            inst1_addr_o = rd0_data.addr;
            inst1_corr_o = rd0_data.corr;
        end
        if (has2) begin
            inst2_o      = rd1_data.inst;
            inst2_addr_o = rd1_data.addr;
            inst2_corr_o = rd1_data.corr;
        end
    end

    assign count_o = count_q;

`ifdef INSTBUF_PERF_EN
    logic [31:0] perf_dual_q;
    logic [31:0] perf_single_q;
    logic [31:0] perf_full_q;

    // Saturating event counters; cleared by reset only, flush leaves them running.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_full_q   <= '0;
        end else begin
            if (pop_n == 2'd2 && perf_dual_q != '1) begin
                perf_dual_q <= perf_dual_q + 32'd1;
            end
            if (pop_n == 2'd1 && perf_single_q != '1) begin
                perf_single_q <= perf_single_q + 32'd1;
            end
            if (full_o && if_inst1_valid && perf_full_q != '1) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
        end
    end

    assign perf_dual_o   = perf_dual_q;
    assign perf_single_o = perf_single_q;
    assign perf_full_o   = perf_full_q;
`endif

endmodule

// File: tb/tb_inst_buffer_dual.sv
// Purpose: randomized and directed self-checking bench for inst_buffer_dual against a queue model.
// Latency: checks outputs on the falling edge after each rising edge.
// Backpressure: model drops any push offered while fewer than 2 slots are free.
module tb_inst_buffer_dual;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CORR_W = 88;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic              if_inst1_valid, if_inst2_valid;
    logic [31:0]       if_inst1, if_inst2, if_addr1, if_addr2;
    logic [CORR_W-1:0] if_corr1, if_corr2;
    logic              full_o, issue_i, issued_i, issue_en_o, inst2_valid_o;
    logic [31:0]       inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic [CORR_W-1:0] inst1_corr_o, inst2_corr_o;
    logic [ADDR_W:0]   count_o;
`ifdef INSTBUF_PERF_EN
    logic [31:0]       perf_dual_o, perf_single_o, perf_full_o;
`endif

    always #5 clk = ~clk;

    inst_buffer_dual #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CORR_W(CORR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_inst1_valid (if_inst1_valid),
        .if_inst2_valid (if_inst2_valid),
        .if_inst1       (if_inst1),
        .if_inst2       (if_inst2),
        .if_addr1       (if_addr1),
        .if_addr2       (if_addr2),
        .if_corr1       (if_corr1),
        .if_corr2       (if_corr2),
        .full_o         (full_o),
        .issue_i        (issue_i),
        .issued_i       (issued_i),
        .issue_en_o     (issue_en_o),
        .inst2_valid_o  (inst2_valid_o),
        .inst1_o        (inst1_o),
        .inst2_o        (inst2_o),
        .inst1_addr_o   (inst1_addr_o),
        .inst2_addr_o   (inst2_addr_o),
        .inst1_corr_o   (inst1_corr_o),
        .inst2_corr_o   (inst2_corr_o),
        .count_o        (count_o)
`ifdef INSTBUF_PERF_EN
        ,
        .perf_dual_o    (perf_dual_o),
        .perf_single_o  (perf_single_o),
        .perf_full_o    (perf_full_o)
`endif
    );

    // Reference model: an ordered queue of entries, oldest first.
    typedef struct {
        logic [31:0]       inst;
        logic [31:0]       addr;
        logic [CORR_W-1:0] corr;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int unsigned m_dual = 0, m_single = 0, m_full = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t slot(input int i);
        ent_t e;
        e.inst = '0;
        e.addr = '0;
        e.corr = '0;
        if (i < q.size()) e = q[i];
        return e;
    endfunction

    function automatic logic [CORR_W-1:0] rand_corr();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic check_outputs();
        int   n;
        ent_t h0, h1;
        n  = q.size();
        h0 = slot(0);
        h1 = slot(1);
        check_val("count", count_o, n);
        check_val("full", full_o, n > DEPTH - 2);
        check_val("issue_en", issue_en_o, n >= 1);
        check_val("inst2_valid", inst2_valid_o, n >= 2);
        check_val("inst1", inst1_o, h0.inst);
        check_val("inst1_addr", inst1_addr_o, h0.addr);
        check_val("inst1_corr", inst1_corr_o, h0.corr);
        check_val("inst2", inst2_o, h1.inst);
        check_val("inst2_addr", inst2_addr_o, h1.addr);
        check_val("inst2_corr", inst2_corr_o, h1.corr);
`ifdef INSTBUF_PERF_EN
        check_val("perf_dual", perf_dual_o, m_dual);
        check_val("perf_single", perf_single_o, m_single);
        check_val("perf_full", perf_full_o, m_full);
`endif
    endtask

    // Advance one clock: update the model from the current inputs, then check.
    task automatic tick();
        int   pn, popn, n;
        bit   full_m;
        ent_t e1, e2;
        n      = q.size();
        full_m = n > DEPTH - 2;
        popn   = 0;
        if (issued_i && n > 0) popn = (issue_i && n >= 2) ? 2 : 1;
        pn = 0;
        if (!full_m && !flush && if_inst1_valid) pn = if_inst2_valid ? 2 : 1;
        e1.inst = if_inst1; e1.addr = if_addr1; e1.corr = if_corr1;
        e2.inst = if_inst2; e2.addr = if_addr2; e2.corr = if_corr2;
        if (rst) begin
            m_dual = 0; m_single = 0; m_full = 0;
        end else begin
            if (popn == 2) m_dual++;
            if (popn == 1) m_single++;
            if (full_m && if_inst1_valid) m_full++;
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            repeat (popn) q.delete(0);
            if (pn >= 1) q.push_back(e1);
            if (pn == 2) q.push_back(e2);
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        rst = 0; flush = 0;
        if_inst1_valid = 0; if_inst2_valid = 0;
        if_inst1 = '0; if_inst2 = '0; if_addr1 = '0; if_addr2 = '0;
        if_corr1 = '0; if_corr2 = '0;
        issue_i = 0; issued_i = 0;
    endtask

    task automatic push_pair(input logic [31:0] pc);
        if_inst1_valid = 1; if_inst2_valid = 1;
        if_inst1 = $urandom; if_inst2 = $urandom;
        if_addr1 = pc; if_addr2 = pc + 32'd4;
        if_corr1 = rand_corr(); if_corr2 = rand_corr();
    endtask

    initial begin
        logic [31:0] pc;
        int unsigned single_before;

        idle();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        check_val("rst_count", count_o, 0);
        check_val("rst_full", full_o, 0);

        // First pair from the boot vector.
        push_pair(32'hBFC0_0000);
        if_inst1 = 32'h2401_0001; if_inst2 = 32'h2402_0002;
        tick();
        idle();
        check_val("t1_count", count_o, 2);
        check_val("t1_inst1", inst1_o, 32'h2401_0001);
        check_val("t1_inst2_addr", inst2_addr_o, 32'hBFC0_0004);
        check_val("t1_inst2_valid", inst2_valid_o, 1);

        // Single retire shifts the former second entry to the head.
        issued_i = 1; issue_i = 0;
        tick();
        idle();
        check_val("t2_count", count_o, 1);
        check_val("t2_inst1", inst1_o, 32'h2402_0002);
        check_val("t2_inst2", inst2_o, 0);

        // Slot 2 valid without slot 1 is ignored.
        if_inst2_valid = 1; if_inst2 = 32'hDEAD_BEEF; if_addr2 = 32'h1234_5678;
        tick();
        idle();
        check_val("orphan_slot2", count_o, 1);

        // Fill to 15 entries, then a pair offered with a dual pop is dropped.
        pc = 32'hBFC0_0008;
        for (int i = 0; i < 7; i++) begin
            push_pair(pc);
            pc += 32'd8;
            tick();
        end
        idle();
        check_val("fill_full", full_o, 1);
        push_pair(pc);
        issued_i = 1; issue_i = 1;
        tick();
        check_val("full_reject", count_o, 13);

        // Steady dual push/pop so both pointers wrap repeatedly.
        for (int i = 0; i < 20; i++) begin
            push_pair(pc);
            pc += 32'd8;
            issued_i = 1; issue_i = 1;
            tick();
            check_val("wrap_pc_step", inst2_addr_o - inst1_addr_o, 4);
        end
        idle();

        // Drain to 6, then flush with a push and a retire in the same cycle.
        issued_i = 1; issue_i = 1;
        repeat (3) tick();
        issue_i = 0;
        tick();
        idle();
        check_val("pre_flush_count", count_o, 6);
        push_pair(pc);
        issued_i = 1; issue_i = 1; flush = 1;
        tick();
        idle();
        check_val("flush_count", count_o, 0);
        check_val("flush_issue_en", issue_en_o, 0);
        check_val("flush_inst1_addr", inst1_addr_o, 0);

        // Dual decision with a single entry retires exactly one.
        if_inst1_valid = 1; if_inst1 = 32'h2403_0003; if_addr1 = 32'hBFC0_1000;
        tick();
        idle();
        single_before = m_single;
        issued_i = 1; issue_i = 1;
        tick();
        idle();
        check_val("dual_on_one", count_o, 0);
        check_val("dual_on_one_single", m_single - single_before, 1);

        // Randomized traffic with occasional flush and one reset.
        for (int i = 0; i < 800; i++) begin
            if_inst1_valid = ($urandom_range(0, 3) != 0);
            if_inst2_valid = $urandom_range(0, 1);
            if_inst1 = $urandom; if_inst2 = $urandom;
            if_addr1 = $urandom; if_addr2 = $urandom;
            if_corr1 = rand_corr(); if_corr2 = rand_corr();
            issued_i = ($urandom_range(0, 2) != 0);
            issue_i  = $urandom_range(0, 1);
            flush    = ($urandom_range(0, 39) == 0);
            rst      = (i == 400);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_buffer_dual.md
Name: inst_buffer_dual

Overview:
- Circular instruction queue between fetch (IF) and the dual-issue decode stage.
- Accepts up to 2 fetched instructions per cycle, each with PC and BPU correction pack.
- Presents the two oldest entries to decode.
- Retires 1 or 2 entries per cycle, based on decode's issue decision (single/dual) and its issued handshake.
- Flushed on branch mispredict or exception redirect.

Parameters:
- DEPTH, 16, number of entries; power of 2, ≥4.
- ADDR_W, 4, log2(DEPTH); pointer width.
- CORR_W, 88, width of the BPU correction pack; bit CORR_W-1 is its valid/taken flag.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries; priority over push and pop.
- if_inst1_valid  in  1  slot-1 fetch valid.
- if_inst2_valid  in  1  slot-2 fetch valid; meaningful only with if_inst1_valid.
- if_inst1, if_inst2  in  32 each  fetched instruction words.
- if_addr1, if_addr2  in  32 each  instruction PCs.
- if_corr1, if_corr2  in  CORR_W each  BPU correction packs.
- full_o  out  1  fewer than 2 free slots; IF must hold its pair.
- issue_i  in  1  decode decision: ISSUE_DUAL=1, ISSUE_SINGLE=0.
- issued_i  in  1  decode consumed this cycle.
- issue_en_o  out  1  at least 1 valid entry.
- inst2_valid_o  out  1  at least 2 valid entries.
- inst1_o, inst2_o  out  32 each  head and head+1 instruction.
- inst1_addr_o, inst2_addr_o  out  32 each  head and head+1 PC.
- inst1_corr_o, inst2_corr_o  out  CORR_W each  head and head+1 correction pack.
- count_o  out  ADDR_W+1  current occupancy.

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH-entry array of {inst, addr, corr}.
  - head and tail are ADDR_W bits and wrap naturally modulo DEPTH.
  - count is ADDR_W+1 bits, range 0..DEPTH.
- full_o = (count > DEPTH-2); combinational from registered count.
- Push:
  - push_n = 0 if full_o or flush.
  - Otherwise push_n = if_inst1_valid + (if_inst1_valid & if_inst2_valid).
  - Slot 1 is written to tail and slot 2 to tail+1 (mod DEPTH); tail += push_n.
  - if_inst2_valid without if_inst1_valid is ignored (push_n = 0).
  - A push while full_o=1 is rejected even if a pop occurs the same cycle.
- Pop:
  - pop_n = 0 if !issued_i or count == 0.
  - Else pop_n = 2 if issue_i == ISSUE_DUAL and count ≥ 2.
  - Else pop_n = 1.
  - head += pop_n.
- Simultaneous push and pop: count_next = count + push_n - pop_n, in the same cycle.
- Empty:
  - Entries are written to storage and are visible on outputs the cycle after push; there is no same-cycle bypass.
- Read outputs (combinational from head):
  - When count == 0, all inst/addr/corr outputs for slot 1 are forced to 0, and issue_en_o = 0.
  - When count < 2, all slot-2 outputs are forced to 0 (NOP, PC 0, corr 0), and inst2_valid_o = 0.
  - A dual decision with a single entry therefore retires only 1 entry.
- flush: head = tail = count = 0 at the next edge; same-cycle push and pop are discarded.
- rst: same effect as flush; storage contents are not cleared. After reset all outputs are 0 and full_o = 0.
- Reset or flush mid-stream: in-flight entries are lost with no partial retire.
- Outside rst/flush, pop never exceeds count and push never exceeds free space.

Optional Feature:
- Macro INSTBUF_PERF_EN.
- When defined, adds three 32-bit saturating counters:
  - perf_dual_o: cycles with pop_n == 2.
  - perf_single_o: cycles with pop_n == 1.
  - perf_full_o: cycles with full_o & if_inst1_valid.
- The counters clear on rst only; flush does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ISSUE_DUAL and ISSUE_SINGLE;
  - CORR_W (SIZE_OF_CORR_PACK);
  - ZeroWord and the NOP encoding;
  - an instbuf_entry_t struct {inst, addr, corr}.
- Sub-module instbuf_ram: DEPTH×entry register array with 2 write ports (tail, tail+1) and 2 async read ports (head, head+1).
- Top level holds pointers, count, handshake and output masking.

Test Plan:
- Reset, then push {0x24010001 @0xBFC00000, 0x24020002 @0xBFC00004}; next cycle count_o=2, inst1_o=0x24010001, inst2_addr_o=0xBFC00004, inst2_valid_o=1.
- With 2 entries, issued_i=1, issue_i=ISSUE_SINGLE → count_o=1, new inst1_o = former inst2; inst2 outputs 0, inst2_valid_o=0.
- Push pairs without popping until count=15 → full_o=1. Then push a pair with a dual pop in the same cycle → push rejected, count_o=13.
- Run 20 push/pop cycles of 2 each so head and tail wrap past index 15 → FIFO order preserved, PCs strictly +4 at the outputs.
- count=6, assert flush together with a valid push pair and issued_i=1 → next cycle count_o=0, issue_en_o=0, all outputs 0.
- Single entry, issue_i=ISSUE_DUAL, issued_i=1 → count_o=0; with INSTBUF_PERF_EN, perf_single_o increments by 1.
